// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate-format enum and decode flag record for the
// decode-stage immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6
  } imm_type_e;

  // Width-independent part of a decoded record; imm/zimm travel beside it
  // because their width follows XLEN.
  typedef struct packed {
    imm_type_e imm_type;
    logic      illegal;
  } dec_flags_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> immediate/format/illegal decode for one
// 32-bit RV instruction, sign-extended to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] zimm,
  output dec_flags_t      flags
);

  localparam bit IS64 = (XLEN == 64);

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;

  always_comb begin
    i_imm = inst[31:20];
    s_imm = {inst[31:25], inst[11:7]};
    b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    u_imm = {inst[31:12], 12'b0};

    imm            = '0;
    zimm           = '0;
    flags.imm_type = IMM_NONE;
    flags.illegal  = 1'b0;

    // Casting a signed field to XLEN performs the sign extension from inst[31].
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        flags.imm_type = IMM_I;
        imm            = XLEN'(i_imm);
      end
      OPC_OP_IMM_32: begin
        if (IS64) begin
          flags.imm_type = IMM_I;
          imm            = XLEN'(i_imm);
        end else begin
          flags.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        flags.imm_type = IMM_S;
        imm            = XLEN'(s_imm);
      end
      OPC_BRANCH: begin
        flags.imm_type = IMM_B;
        imm            = XLEN'(b_imm);
      end
      OPC_JAL: begin
        flags.imm_type = IMM_J;
        imm            = XLEN'(j_imm);
      end
      OPC_LUI, OPC_AUIPC: begin
        flags.imm_type = IMM_U;
        imm            = XLEN'(u_imm);
      end
      OPC_SYSTEM: begin
        flags.imm_type = IMM_CSR;
        imm            = XLEN'(inst[31:20]);
        if (inst[14]) zimm = XLEN'(inst[19:15]);
      end
      OPC_OP: begin
        flags.imm_type = IMM_NONE;
      end
      OPC_OP_32: begin
        flags.illegal = !IS64;
      end
      default: begin
        flags.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode feeding a 2-entry skid buffer
// with valid/ready on both sides and a saturating illegal counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  zimm,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_cnt
);

  // Handshake: a transfer happens on a posedge where valid and ready are both
  // high; producers hold data stable while valid is high and ready is low.

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] zimm;
    dec_flags_t      flags;
  } ent_t;

  ent_t main_q, skid_q, dec_e;
  logic main_v, skid_v;
  logic in_xfer, out_xfer;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst  (inst),
    .imm   (dec_e.imm),
    .zimm  (dec_e.zimm),
    .flags (dec_e.flags)
  );

  assign in_ready = !skid_v;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_v && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
      ill_cnt <= '0;
    end else begin
      if (out_xfer && main_q.flags.illegal && (ill_cnt != {CNT_W{1'b1}}))
        ill_cnt <= ill_cnt + 1'b1;

      // in_ready is low whenever skid is occupied, so skid refill and
      // input capture never coincide.
      if (!main_v || out_xfer) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else if (in_xfer) begin
          main_q <= dec_e;
          main_v <= 1'b1;
        end else begin
          main_v <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q <= dec_e;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid = main_v;
  assign imm       = main_q.imm;
  assign zimm      = main_q.zimm;
  assign imm_type  = main_q.flags.imm_type;
  assign illegal   = main_q.flags.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32/CNT_W=16 and an
// XLEN=64/CNT_W=2 instance share one input stream and handshake.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, zimm32;
  logic [2:0]  ty32;
  logic [15:0] cnt32;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, zimm64;
  logic [2:0]  ty64;
  logic [1:0]  cnt64;

  int total = 0;
  int bad = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int exp_cnt32 = 0;
  int exp_cnt64 = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] zimm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  exp_t exp_q32[$];
  exp_t exp_q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .inst(inst),
    .out_valid(vld32), .out_ready(out_ready), .imm(imm32), .zimm(zimm32),
    .imm_type(ty32), .illegal(ill32), .ill_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .inst(inst),
    .out_valid(vld64), .out_ready(out_ready), .imm(imm64), .zimm(zimm64),
    .imm_type(ty64), .illegal(ill64), .ill_cnt(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: immediates rebuilt by weighted sums of instruction fields.
  function automatic exp_t model(input logic [31:0] i, input bit x64);
    exp_t e;
    longint s;
    logic [63:0] sg;
    e  = '0;
    s  = longint'($signed(i));
    sg = 64'(s >>> 31);  // all ones for negative, zero otherwise
    case (i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        e.ty = IMM_I; e.imm = 64'(s >>> 20);
      end
      OPC_OP_IMM_32: begin
        if (x64) begin e.ty = IMM_I; e.imm = 64'(s >>> 20); end
        else e.ill = 1'b1;
      end
      OPC_STORE: begin
        e.ty = IMM_S; e.imm = 64'(s >>> 25) * 64'd32 + 64'(i[11:7]);
      end
      OPC_BRANCH: begin
        e.ty = IMM_B;
        e.imm = sg * 64'd4096 + 64'(i[7]) * 64'd2048 + 64'(i[30:25]) * 64'd32
              + 64'(i[11:8]) * 64'd2;
      end
      OPC_JAL: begin
        e.ty = IMM_J;
        e.imm = sg * 64'd1048576 + 64'(i[19:12]) * 64'd4096 + 64'(i[20]) * 64'd2048
              + 64'(i[30:21]) * 64'd2;
      end
      OPC_LUI, OPC_AUIPC: begin
        e.ty = IMM_U; e.imm = 64'(s >>> 12) * 64'd4096;
      end
      OPC_SYSTEM: begin
        e.ty = IMM_CSR; e.imm = 64'(i[31:20]);
        e.zimm = i[14] ? 64'(i[19:15]) : 64'd0;
      end
      OPC_OP: e.ty = IMM_NONE;
      OPC_OP_32: e.ill = !x64;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one instruction; entered and left at posedge+1.
  task automatic send(input logic [31:0] x);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    inst = x;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = rdy32;
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc) begin
      exp_q32.push_back(model(x, 1'b0));
      exp_q64.push_back(model(x, 1'b1));
    end else begin
      total++; bad++;
      $display("FAIL send_timeout inst=%h in_ready stayed %b, required 1", x, rdy32);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while ((exp_q32.size() != 0 || exp_q64.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_pending", 64'(exp_q32.size() + exp_q64.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [16];
    logic [31:0] r;
    opcs = '{OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_OP_IMM_32, OPC_STORE,
             OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_OP, OPC_OP_32,
             7'h7F, 7'h00, 7'h2B};
    r = $urandom();
    return {r[31:7], opcs[$urandom_range(0, 15)]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: occupancy-based valid/ready checks, then pop-and-compare on output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid32", 64'(vld32), 64'(exp_q32.size() > 0));
        chk("out_valid64", 64'(vld64), 64'(exp_q64.size() > 0));
        chk("in_ready32", 64'(rdy32), 64'(exp_q32.size() < 2));
        chk("in_ready64", 64'(rdy64), 64'(exp_q64.size() < 2));
        chk("ill_cnt32", 64'(cnt32), 64'(exp_cnt32));
        chk("ill_cnt64", 64'(cnt64), 64'(exp_cnt64));
        if (vld32 && out_ready && exp_q32.size() > 0) begin
          e = exp_q32.pop_front();
          chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
          chk("zimm32", 64'(zimm32), 64'(e.zimm[31:0]));
          chk("type32", 64'(ty32), 64'(e.ty));
          chk("illegal32", 64'(ill32), 64'(e.ill));
          if (e.ill && exp_cnt32 < 65535) exp_cnt32++;
        end
        if (vld64 && out_ready && exp_q64.size() > 0) begin
          e = exp_q64.pop_front();
          chk("imm64", imm64, e.imm);
          chk("zimm64", zimm64, e.zimm);
          chk("type64", 64'(ty64), 64'(e.ty));
          chk("illegal64", 64'(ill64), 64'(e.ill));
          if (e.ill && exp_cnt64 < 3) exp_cnt64++;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_zimm32", 64'(zimm32), 64'd0);
    chk("rst_type32", 64'(ty32), 64'(IMM_NONE));
    chk("rst_illegal32", 64'(ill32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_valid64", 64'(vld64), 64'd0);
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_cnt32", 64'(cnt32), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs();

    // Directed encodings with known immediates
    send(32'hFFF00093);
    send(32'hFE000EE3);
    send(32'h800002B7);
    send(32'h3002D073);
    send(32'h0000007F);
    drain();

    // Stall: two accepted, in_ready falls, order kept
    ready_mode = 0;
    idle(1);
    send(32'h00A00113);
    send(32'h00112223);
    idle(1);
    chk("stall_in_ready", 64'(rdy32), 64'd0);
    idle(1);
    ready_mode = 1;
    send(32'h008000EF);
    drain();

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) send(32'h0000007F);
    drain();
    chk("sat_cnt64", 64'(cnt64), 64'd3);

    ready_mode = 2;
    for (int k = 0; k < 300; k++) begin
      send(rand_inst());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Reset with both entries full and stalled
    ready_mode = 0;
    send(rand_inst());
    send(rand_inst());
    idle(1);
    rst_n = 1'b0;
    exp_q32.delete();
    exp_q64.delete();
    exp_cnt32 = 0;
    exp_cnt64 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 1;
    check_reset_outputs();

    ready_mode = 2;
    for (int k = 0; k < 100; k++) send(rand_inst());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
